// File: rtl/obj_scan_scheduler_if.sv
// Signal bundle between the OAM scan scheduler, its lookup unit and the object consumer.
// Object handshake: obj_valid stays high with obj_index/obj_row frozen until a cycle with obj_valid & obj_ready; obj_ready is ignored while obj_valid is low.
`timescale 1ns/1ps
interface obj_scan_scheduler_if;
    logic       linestart;
    logic [7:0] vcount;
    logic       startrow;
    logic       step;
    logic [7:0] objy;
    logic [6:0] vsize;
    logic       rotation;
    logic       dblsize;
    logic [1:0] objmode;
    logic       obj_valid;
    logic       obj_ready;
    logic [6:0] obj_index;
    logic [6:0] obj_row;
    logic       scan_busy;
    logic       scan_done;

    modport slave (
        input  linestart, vcount, objy, vsize, rotation, dblsize, objmode, obj_ready,
        output startrow, step, obj_valid, obj_index, obj_row, scan_busy, scan_done
    );

    modport master (
        output linestart, vcount, objy, vsize, rotation, dblsize, objmode, obj_ready,
        input  startrow, step, obj_valid, obj_index, obj_row, scan_busy, scan_done
    );
endinterface

// File: rtl/obj_scan_scheduler.sv
// Walks all 128 OAM entries for one line and offers each visible object downstream.
// Optional OBJ_SCAN_LIMIT_EN: end the scan early once 128 objects were transferred on a line.
`timescale 1ns/1ps
module obj_scan_scheduler (
    input  logic                       i_clock,
    input  logic                       i_reset_n,
    obj_scan_scheduler_if.slave        io_scan,
    output logic [2:0]                 o_dbg_state
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_WAIT1 = 3'd2,
        S_WAIT2 = 3'd3,
        S_EVAL  = 3'd4,
        S_OFFER = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic [6:0] r_idx;
    logic [7:0] r_vcount;
    logic [6:0] r_row;
    logic [7:0] w_height;
    logic [7:0] w_row;
    logic       w_hidden;
    logic       w_visible;
    logic       w_last;
    logic       w_xfer;
    logic       w_limit_hit;
    logic       w_step;
    logic       w_startrow;

    // Doubled height only applies to affine objects; non-affine with dblsize set is disabled.
    assign w_height  = (io_scan.rotation & io_scan.dblsize) ? {io_scan.vsize, 1'b0}
                                                            : {1'b0, io_scan.vsize};
    assign w_row     = r_vcount - io_scan.objy;
    assign w_hidden  = (~io_scan.rotation & io_scan.dblsize) | (io_scan.objmode == 2'd3);
    assign w_visible = (w_row < w_height) & ~w_hidden;
    assign w_last    = (r_idx == 7'd127);
    assign w_xfer    = (r_state == S_OFFER) & io_scan.obj_ready;

`ifdef OBJ_SCAN_LIMIT_EN
    logic [7:0] r_count;

    // A count of 127 before this transfer means the line budget is now used up.
    assign w_limit_hit = (r_count == 8'd127);

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_count <= 8'd0;
        end else if (io_scan.linestart) begin
            r_count <= 8'd0;
        end else if (w_xfer) begin
            r_count <= r_count + 8'd1;
        end
    end
`else
    assign w_limit_hit = 1'b0;
`endif

    always_comb begin
        w_next     = r_state;
        w_step     = 1'b0;
        w_startrow = (r_state == S_START);
        if (io_scan.linestart) begin
            w_next = S_START;
        end else begin
            case (r_state)
                S_IDLE:  w_next = S_IDLE;
                S_START: w_next = S_WAIT1;
                S_WAIT1: w_next = S_WAIT2;
                S_WAIT2: w_next = S_EVAL;
                S_EVAL: begin
                    if (w_visible) begin
                        w_next = S_OFFER;
                    end else if (!w_last) begin
                        w_step = 1'b1;
                        w_next = S_WAIT1;
                    end else begin
                        w_next = S_DONE;
                    end
                end
                S_OFFER: begin
                    if (w_xfer) begin
                        if (w_last || w_limit_hit) begin
                            w_next = S_DONE;
                        end else begin
                            w_step = 1'b1;
                            w_next = S_WAIT1;
                        end
                    end
                end
                S_DONE:  w_next = S_IDLE;
                default: w_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state  <= S_IDLE;
            r_idx    <= 7'd0;
            r_vcount <= 8'd0;
            r_row    <= 7'd0;
        end else begin
            r_state <= w_next;
            if (io_scan.linestart) begin
                r_vcount <= io_scan.vcount;
                r_idx    <= 7'd0;
            end else if (w_step) begin
                r_idx <= r_idx + 7'd1;
            end
            // Freeze the row as the object is offered so the payload cannot move.
            if (r_state == S_EVAL) begin
                r_row <= w_row[6:0];
            end
        end
    end

    assign io_scan.startrow  = w_startrow;
    assign io_scan.step      = w_step;
    assign io_scan.obj_valid = (r_state == S_OFFER);
    assign io_scan.obj_index = r_idx;
    assign io_scan.obj_row   = r_row;
    assign io_scan.scan_busy = (r_state != S_IDLE);
    assign io_scan.scan_done = (r_state == S_DONE);
    assign o_dbg_state       = r_state;
endmodule

// File: tb/tb_obj_scan_scheduler.sv
// Bench for obj_scan_scheduler: OAM lookup model, table of single-object scans, corner sequences.
`timescale 1ns/1ps
module tb_obj_scan_scheduler;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    obj_scan_scheduler_if bus ();
    logic [2:0] dbg_state;

    obj_scan_scheduler dut (
        .i_clock     (clk),
        .i_reset_n   (rst_n),
        .io_scan     (bus),
        .o_dbg_state (dbg_state)
    );

    // OAM lookup model: address rewinds on startrow, advances on step.
    logic [7:0] oam_y    [128];
    logic [6:0] oam_sz   [128];
    logic       oam_rot  [128];
    logic       oam_dbl  [128];
    logic [1:0] oam_mode [128];
    logic [6:0] lk_addr;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)            lk_addr <= 7'd0;
        else if (bus.startrow) lk_addr <= 7'd0;
        else if (bus.step)     lk_addr <= lk_addr + 7'd1;
    end

    assign bus.objy     = oam_y[lk_addr];
    assign bus.vsize    = oam_sz[lk_addr];
    assign bus.rotation = oam_rot[lk_addr];
    assign bus.dblsize  = oam_dbl[lk_addr];
    assign bus.objmode  = oam_mode[lk_addr];

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Scoreboard: {index, row} of each expected transfer, in order.
    logic [13:0] exp_q[$];
    int done_cnt = 0;
    int overlap_cnt = 0;
    int xfer_cnt = 0;
    logic [13:0] sb_e;

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.startrow && bus.step) overlap_cnt++;
            if (bus.scan_done) done_cnt++;
            if (bus.obj_valid && bus.obj_ready) begin
                xfer_cnt++;
                check("sb_has_entry", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    sb_e = exp_q.pop_front();
                    check("xfer_index", bus.obj_index, sb_e[13:7]);
                    check("xfer_row", bus.obj_row, sb_e[6:0]);
                end
            end
        end
    end

    task automatic fill_all(input logic [7:0] y, input logic [6:0] sz);
        for (int i = 0; i < 128; i++) begin
            oam_y[i] = y; oam_sz[i] = sz; oam_rot[i] = 1'b0; oam_dbl[i] = 1'b0; oam_mode[i] = 2'd0;
        end
    endtask

    task automatic wait_done(output bit to);
        to = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (bus.scan_done) begin to = 1'b0; break; end
        end
        #1;
    endtask

    task automatic run_scan(input logic [7:0] vc, input bit rnd_ready, output int busy_cyc, output bit to);
        @(posedge clk); #1;
        bus.vcount = vc;
        bus.linestart = 1'b1;
        busy_cyc = 0;
        to = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (bus.scan_done) begin to = 1'b0; break; end
            if (bus.scan_busy) busy_cyc++;
            @(posedge clk); #1;
            bus.linestart = 1'b0;
            if (rnd_ready) bus.obj_ready = 1'($urandom_range(0, 1));
        end
        #1;
    endtask

    typedef struct {
        logic [7:0] vc;
        logic [6:0] idx;
        logic [7:0] y;
        logic [6:0] sz;
        logic       rot;
        logic       dbl;
        logic [1:0] mode;
        logic       vis;
        logic [6:0] row;
    } vec_t;

    vec_t vecs[12];

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        bit to;
        int d0;
        int x0;
        logic [6:0] cap_idx;
        logic [6:0] cap_row;
        int drops;
        int steps;
        bit found;

        vecs[0]  = '{8'd10,  7'd0,   8'd5,   7'd8,   1'b0, 1'b0, 2'd0, 1'b1, 7'd5};
        vecs[1]  = '{8'd2,   7'd3,   8'd250, 7'd16,  1'b0, 1'b0, 2'd0, 1'b1, 7'd8};
        vecs[2]  = '{8'd40,  7'd7,   8'd0,   7'd32,  1'b1, 1'b1, 2'd0, 1'b1, 7'd40};
        vecs[3]  = '{8'd40,  7'd7,   8'd0,   7'd32,  1'b0, 1'b1, 2'd0, 1'b0, 7'd0};
        vecs[4]  = '{8'd40,  7'd9,   8'd0,   7'd32,  1'b1, 1'b0, 2'd0, 1'b0, 7'd0};
        vecs[5]  = '{8'd20,  7'd127, 8'd10,  7'd11,  1'b0, 1'b0, 2'd0, 1'b1, 7'd10};
        vecs[6]  = '{8'd20,  7'd5,   8'd10,  7'd10,  1'b0, 1'b0, 2'd0, 1'b0, 7'd0};
        vecs[7]  = '{8'd30,  7'd60,  8'd0,   7'd40,  1'b0, 1'b0, 2'd3, 1'b0, 7'd0};
        vecs[8]  = '{8'd30,  7'd60,  8'd0,   7'd40,  1'b0, 1'b0, 2'd2, 1'b1, 7'd30};
        vecs[9]  = '{8'd0,   7'd1,   8'd0,   7'd1,   1'b0, 1'b0, 2'd0, 1'b1, 7'd0};
        vecs[10] = '{8'd100, 7'd2,   8'd50,  7'd64,  1'b1, 1'b1, 2'd1, 1'b1, 7'd50};
        vecs[11] = '{8'd255, 7'd4,   8'd0,   7'd127, 1'b1, 1'b1, 2'd0, 1'b0, 7'd0};

        bus.linestart = 1'b0;
        bus.vcount = 8'd0;
        bus.obj_ready = 1'b1;
        fill_all(8'd200, 7'd8);

        // Reset state, both during and after reset.
        #3;
        check("rst_state", dbg_state, 0);
        check("rst_outputs", {bus.startrow, bus.step, bus.obj_valid, bus.scan_busy, bus.scan_done}, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_startrow", bus.startrow, 0);
        check("idle_step", bus.step, 0);
        check("idle_valid", bus.obj_valid, 0);
        check("idle_index", bus.obj_index, 0);
        check("idle_row", bus.obj_row, 0);
        check("idle_busy", bus.scan_busy, 0);
        check("idle_done", bus.scan_done, 0);

        // Single-object scans: one candidate entry among invisible fillers.
        for (int v = 0; v < 12; v++) begin
            fill_all(8'd200, 7'd8);
            oam_y[vecs[v].idx] = vecs[v].y;
            oam_sz[vecs[v].idx] = vecs[v].sz;
            oam_rot[vecs[v].idx] = vecs[v].rot;
            oam_dbl[vecs[v].idx] = vecs[v].dbl;
            oam_mode[vecs[v].idx] = vecs[v].mode;
            if (vecs[v].vis) exp_q.push_back({vecs[v].idx, vecs[v].row});
            d0 = done_cnt;
            x0 = xfer_cnt;
            run_scan(vecs[v].vc, 1'b0, cyc, to);
            check($sformatf("vec%0d_timeout", v), to, 0);
            check($sformatf("vec%0d_busy_cycles", v), cyc, 385 + int'(vecs[v].vis));
            check($sformatf("vec%0d_done_pulses", v), done_cnt - d0, 1);
            check($sformatf("vec%0d_xfers", v), xfer_cnt - x0, int'(vecs[v].vis));
            check($sformatf("vec%0d_sb_empty", v), exp_q.size(), 0);
        end

        // Backpressure: downstream stalls 20 cycles with an object on offer.
        fill_all(8'd200, 7'd8);
        oam_y[4] = 8'd0;
        oam_sz[4] = 7'd20;
        bus.obj_ready = 1'b0;
        exp_q.push_back({7'd4, 7'd5});
        @(posedge clk); #1 bus.vcount = 8'd5; bus.linestart = 1'b1;
        @(posedge clk); #1 bus.linestart = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (bus.obj_valid) begin found = 1'b1; break; end
        end
        check("hold_valid_seen", found, 1);
        cap_idx = bus.obj_index;
        cap_row = bus.obj_row;
        check("hold_index", cap_idx, 4);
        check("hold_row", cap_row, 5);
        drops = 0;
        steps = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (!bus.obj_valid || bus.obj_index != cap_idx || bus.obj_row != cap_row) drops++;
            if (bus.step) steps++;
        end
        check("hold_stable", drops, 0);
        check("hold_no_step", steps, 0);
        @(posedge clk); #1 bus.obj_ready = 1'b1;
        wait_done(to);
        check("hold_timeout", to, 0);
        check("hold_sb_empty", exp_q.size(), 0);

        // Abort at entry 50: restart from entry 0 with the new line.
        fill_all(8'd200, 7'd8);
        oam_y[0] = 8'd5;
        d0 = done_cnt;
        exp_q.push_back({7'd0, 7'd5});
        @(posedge clk); #1 bus.vcount = 8'd10; bus.linestart = 1'b1;
        @(posedge clk); #1 bus.linestart = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (lk_addr == 7'd50) begin found = 1'b1; break; end
        end
        check("abort_reached_50", found, 1);
        @(posedge clk); #1 bus.vcount = 8'd12; bus.linestart = 1'b1;
        exp_q.push_back({7'd0, 7'd7});
        @(posedge clk); #1 bus.linestart = 1'b0;
        @(negedge clk);
        check("abort_startrow", bus.startrow, 1);
        check("abort_no_valid", bus.obj_valid, 0);
        wait_done(to);
        check("abort_timeout", to, 0);
        check("abort_single_done", done_cnt - d0, 1);
        check("abort_sb_empty", exp_q.size(), 0);

        // Randomly throttled consumer with three visible objects.
        fill_all(8'd200, 7'd8);
        for (int k = 1; k <= 3; k++) begin
            oam_y[k * 10] = 8'd0;
            oam_sz[k * 10] = 7'd50;
            exp_q.push_back({7'(k * 10), 7'd7});
        end
        d0 = done_cnt;
        x0 = xfer_cnt;
        run_scan(8'd7, 1'b1, cyc, to);
        bus.obj_ready = 1'b1;
        check("rnd_timeout", to, 0);
        check("rnd_xfers", xfer_cnt - x0, 3);
        check("rnd_done", done_cnt - d0, 1);
        check("rnd_sb_empty", exp_q.size(), 0);

        // Every entry visible: 128 transfers, four cycles per entry.
        fill_all(8'd0, 7'd64);
        for (int i = 0; i < 128; i++) exp_q.push_back({7'(i), 7'd3});
        d0 = done_cnt;
        x0 = xfer_cnt;
        run_scan(8'd3, 1'b0, cyc, to);
        check("full_timeout", to, 0);
        check("full_busy_cycles", cyc, 513);
        check("full_xfers", xfer_cnt - x0, 128);
        check("full_done", done_cnt - d0, 1);
        check("full_sb_empty", exp_q.size(), 0);

        // Reset in the middle of a scan clears outputs at once, no done pulse.
        for (int i = 0; i < 128; i++) exp_q.push_back({7'(i), 7'd3});
        d0 = done_cnt;
        x0 = xfer_cnt;
        @(posedge clk); #1 bus.vcount = 8'd3; bus.linestart = 1'b1;
        @(posedge clk); #1 bus.linestart = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (lk_addr == 7'd20) begin found = 1'b1; break; end
        end
        check("rstmid_reached_20", found, 1);
        check("rstmid_some_xfers", xfer_cnt - x0, 20);
        @(posedge clk); #3 rst_n = 1'b0;
        #1;
        check("rstmid_state", dbg_state, 0);
        check("rstmid_outputs", {bus.startrow, bus.step, bus.obj_valid, bus.scan_busy, bus.scan_done}, 0);
        check("rstmid_index", bus.obj_index, 0);
        check("rstmid_row", bus.obj_row, 0);
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("rstmid_no_done", done_cnt - d0, 0);

        fill_all(8'd200, 7'd8);
        oam_y[0] = 8'd5;
        exp_q.push_back({7'd0, 7'd5});
        d0 = done_cnt;
        run_scan(8'd10, 1'b0, cyc, to);
        check("post_rst_timeout", to, 0);
        check("post_rst_busy_cycles", cyc, 386);
        check("post_rst_done", done_cnt - d0, 1);
        check("post_rst_sb_empty", exp_q.size(), 0);

        check("startrow_step_overlap", overlap_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
